// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, in-flight tag and 2-entry {pc, inst} buffer toward decode.
// Optional perf counters (w_fetch_count, w_squash_count) enabled by `define FETCH_PERFCNT_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        w_clk,
    input  logic        w_rst,
    output logic [5:0]  w_imem_addr,
    input  logic [31:0] w_imem_inst,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_out_valid,
    input  logic        w_out_ready,
    output logic [31:0] w_out_pc,
    output logic [31:0] w_out_inst
`ifdef FETCH_PERFCNT_EN
    ,
    output logic [31:0] w_fetch_count,
    output logic [31:0] w_squash_count
`endif
);

    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [1:0]  r_count;
    logic [31:0] r_pc0, r_inst0, r_pc1, r_inst1;

    logic        pop;
    logic        issue;
    logic [1:0]  kept;
    logic [2:0]  occ;
    logic [1:0]  nxt_count;
    logic [31:0] nxt_pc0, nxt_inst0, nxt_pc1, nxt_inst1;
    logic        unused_rpc_lsbs;

    assign unused_rpc_lsbs = ^w_redirect_pc[1:0];

    assign w_imem_addr = r_pc[7:2];
    assign w_out_valid = (r_count != 2'd0);
    assign w_out_pc    = r_pc0;
    assign w_out_inst  = r_inst0;

    assign pop   = w_out_valid && w_out_ready;
    assign kept  = r_count - {1'b0, pop};
    assign occ   = {1'b0, kept} + {2'b00, r_if_valid};
    assign issue = !w_redirect && (occ < 3'd2);

    // Entry 0 is the head; a pop shifts entry 1 down before the push lands at the first free slot.
    always_comb begin
        nxt_count = kept;
        nxt_pc0   = r_pc0;
        nxt_inst0 = r_inst0;
        nxt_pc1   = r_pc1;
        nxt_inst1 = r_inst1;
        if (pop) begin
            nxt_pc0   = r_pc1;
            nxt_inst0 = r_inst1;
        end
        if (w_redirect) begin
            nxt_count = 2'd0;
        end else if (r_if_valid) begin
            nxt_count = kept + 2'd1;
            if (kept == 2'd0) begin
                nxt_pc0   = r_if_pc;
                nxt_inst0 = w_imem_inst;
            end else begin
                nxt_pc1   = r_if_pc;
                nxt_inst1 = w_imem_inst;
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_count    <= 2'd0;
            r_pc0      <= '0;
            r_inst0    <= '0;
            r_pc1      <= '0;
            r_inst1    <= '0;
        end else begin
            r_count <= nxt_count;
            r_pc0   <= nxt_pc0;
            r_inst0 <= nxt_inst0;
            r_pc1   <= nxt_pc1;
            r_inst1 <= nxt_inst1;
            if (w_redirect) begin
                r_if_valid <= 1'b0;
                r_pc       <= {w_redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_pc       <= r_pc + 32'd4;
            end else begin
                r_if_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERFCNT_EN
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            w_fetch_count  <= '0;
            w_squash_count <= '0;
        end else begin
            if (pop)
                w_fetch_count <= w_fetch_count + 32'd1;
            if (w_redirect)
                w_squash_count <= w_squash_count + 32'(kept) + 32'(r_if_valid);
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed test-plan scenarios with literal expectations,
// then randomized ready/redirect/reset traffic checked every cycle against a queue-based model.
module tb_inst_fetch;

    logic        w_clk;
    logic        w_rst;
    logic [5:0]  w_imem_addr;
    logic [31:0] w_imem_inst;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_inst;
`ifdef FETCH_PERFCNT_EN
    logic [31:0] w_fetch_count;
    logic [31:0] w_squash_count;
`endif

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .w_clk         (w_clk),
        .w_rst         (w_rst),
        .w_imem_addr   (w_imem_addr),
        .w_imem_inst   (w_imem_inst),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_out_valid   (w_out_valid),
        .w_out_ready   (w_out_ready),
        .w_out_pc      (w_out_pc),
        .w_out_inst    (w_out_inst)
`ifdef FETCH_PERFCNT_EN
        ,
        .w_fetch_count (w_fetch_count),
        .w_squash_count(w_squash_count)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Synchronous-read instruction memory
    logic [31:0] mem [0:63];
    always @(posedge w_clk) w_imem_inst <= mem[w_imem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what decode should see, as a queue of fetched {pc, inst}.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_ifv;
    logic [31:0] m_ifpc;
    logic [31:0] m_fc;
    logic [31:0] m_sc;
    bit          m_live = 0;

    initial begin
        bit pop, iss;
        forever begin
            @(posedge w_clk);
            if (w_rst) begin
                m_pc  = 32'h0;
                q.delete();
                m_ifv = 0;
                m_fc  = 0;
                m_sc  = 0;
                m_live = 1;
            end else if (m_live) begin
                pop = (q.size() != 0) && w_out_ready;
                if (pop) begin
                    void'(q.pop_front());
                    m_fc = m_fc + 1;
                end
                if (w_redirect) begin
                    m_sc = m_sc + 32'(q.size()) + 32'(m_ifv);
                    q.delete();
                    m_ifv = 0;
                    m_pc  = {w_redirect_pc[31:2], 2'b00};
                end else begin
                    iss = (q.size() + int'(m_ifv)) < 2;
                    if (m_ifv) q.push_back('{m_ifpc, mem[m_ifpc[7:2]]});
                    if (iss) begin
                        m_ifv  = 1;
                        m_ifpc = m_pc;
                        m_pc   = m_pc + 32'd4;
                    end else begin
                        m_ifv = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge w_clk);
            if (m_live) begin
                chk("model_valid", {31'b0, w_out_valid}, {31'b0, q.size() != 0});
                chk("model_addr", {26'b0, w_imem_addr}, {26'b0, m_pc[7:2]});
                if (q.size() != 0) begin
                    chk("model_pc", w_out_pc, q[0].pc);
                    chk("model_inst", w_out_inst, q[0].inst);
                end
`ifdef FETCH_PERFCNT_EN
                chk("model_fetch_cnt", w_fetch_count, m_fc);
                chk("model_squash_cnt", w_squash_count, m_sc);
`endif
            end
        end
    end

    task automatic cyc();
        @(negedge w_clk);
    endtask

    task automatic head(input string name, input logic [31:0] pc, input logic [31:0] inst);
        chk({name, "_valid"}, {31'b0, w_out_valid}, 32'd1);
        chk({name, "_pc"}, w_out_pc, pc);
        chk({name, "_inst"}, w_out_inst, inst);
    endtask

    initial begin
        w_rst = 1'b1;
        w_out_ready = 1'b1;
        w_redirect = 1'b0;
        w_redirect_pc = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'h0010_0093;
        mem[1] = 32'h0020_0113;
        mem[2] = 32'h0020_81B3;

        // Reset release, streaming
        cyc(); cyc(); cyc();
        chk("rst_valid", {31'b0, w_out_valid}, 32'd0);
        chk("rst_pc", w_out_pc, 32'd0);
        chk("rst_inst", w_out_inst, 32'd0);
        w_rst = 1'b0;
        cyc();
        chk("lat_valid_d1", {31'b0, w_out_valid}, 32'd0);
        chk("lat_addr_d1", {26'b0, w_imem_addr}, 32'd1);
        cyc(); head("stream0", 32'h0, 32'h0010_0093);
        cyc(); head("stream1", 32'h4, 32'h0020_0113);
        cyc(); head("stream2", 32'h8, 32'h0020_81B3);
`ifdef FETCH_PERFCNT_EN
        chk("stream_fetch_cnt", w_fetch_count, 32'd2);
`endif

        // Backpressure
        w_rst = 1'b1;
        cyc();
        chk("rst2_valid", {31'b0, w_out_valid}, 32'd0);
        chk("rst2_addr", {26'b0, w_imem_addr}, 32'd0);
        w_rst = 1'b0;
        cyc(); cyc();
        w_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            head("hold", 32'h0, 32'h0010_0093);
            chk("hold_addr", {26'b0, w_imem_addr}, 32'd2);
        end
        w_out_ready = 1'b1;
        cyc(); head("rel1", 32'h4, 32'h0020_0113);
        chk("rel1_addr", {26'b0, w_imem_addr}, 32'd3);
        cyc(); head("rel2", 32'h8, 32'h0020_81B3);
        w_out_ready = 1'b0;
        cyc(); head("full", 32'h8, 32'h0020_81B3);
`ifdef FETCH_PERFCNT_EN
        chk("full_fetch_cnt", w_fetch_count, 32'd2);
`endif

        // Reset mid-stream with full buffer
        w_rst = 1'b1;
        cyc();
        chk("midrst_valid", {31'b0, w_out_valid}, 32'd0);
        chk("midrst_addr", {26'b0, w_imem_addr}, 32'd0);
`ifdef FETCH_PERFCNT_EN
        chk("midrst_fetch_cnt", w_fetch_count, 32'd0);
        chk("midrst_squash_cnt", w_squash_count, 32'd0);
`endif
        w_rst = 1'b0;
        w_out_ready = 1'b1;
        cyc();
        chk("restart_valid", {31'b0, w_out_valid}, 32'd0);
        cyc(); head("restart", 32'h0, 32'h0010_0093);

        // Redirect to 0x8 while head is pc 0
        w_redirect = 1'b1;
        w_redirect_pc = 32'h8;
        cyc();
        w_redirect = 1'b0;
        chk("redir_valid_r1", {31'b0, w_out_valid}, 32'd0);
        chk("redir_addr_r1", {26'b0, w_imem_addr}, 32'd2);
`ifdef FETCH_PERFCNT_EN
        chk("redir_fetch_cnt", w_fetch_count, 32'd1);
        chk("redir_squash_cnt", w_squash_count, 32'd1);
`endif
        cyc();
        chk("redir_valid_r2", {31'b0, w_out_valid}, 32'd0);
        cyc(); head("redir_tgt", 32'h8, 32'h0020_81B3);

        // Redirect to 0xFD: low bits dropped, then alias of word 0 at 0x100
        w_redirect = 1'b1;
        w_redirect_pc = 32'hFD;
        cyc();
        w_redirect = 1'b0;
        chk("alias_addr", {26'b0, w_imem_addr}, 32'd63);
`ifdef FETCH_PERFCNT_EN
        chk("alias_squash_cnt", w_squash_count, 32'd2);
`endif
        cyc();
        chk("alias_wrap_addr", {26'b0, w_imem_addr}, 32'd0);
        cyc(); head("alias_fc", 32'hFC, 32'h0);
        cyc(); head("alias_100", 32'h100, 32'h0010_0093);

        // Randomized traffic
        w_rst = 1'b1;
        cyc();
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        cyc();
        w_rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            w_out_ready   = ($urandom_range(0, 3) != 0);
            w_redirect    = ($urandom_range(0, 15) == 0);
            w_redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : 32'($urandom);
            w_rst         = ($urandom_range(0, 199) == 0);
        end
        w_rst = 1'b0;
        w_redirect = 1'b0;
        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit: the requesting side of the synchronous-read instruction memory. It owns the PC, drives the 6-bit word address into the instruction memory every cycle, tags the request that is in flight, and captures the returned word one cycle later into a 2-entry buffer. The buffer feeds decode over a valid/ready handshake and supports branch/jump redirect with squash.

## Interface
- RESET_PC, default 32'h0000_0000: PC loaded on reset.

- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  synchronous reset, active-high.
- w_imem_addr  out  6  word address to instruction memory, pc[7:2], combinational from the PC register.
- w_imem_inst  in  32  registered read data; holds mem[addr] sampled at the previous posedge.
- w_redirect  in  1  redirect request from execute.
- w_redirect_pc  in  32  redirect target; bits [1:0] ignored.
- w_out_valid  out  1  buffer head holds an instruction.
- w_out_ready  in  1  decode accepts the head this cycle.
- w_out_pc  out  32  PC of the head entry.
- w_out_inst  out  32  instruction of the head entry.
- w_fetch_count  out  32  instructions delivered (FETCH_PERFCNT_EN only).
- w_squash_count  out  32  entries and in-flight words discarded by redirect (FETCH_PERFCNT_EN only).

## Operation
- State:
  - r_pc (32).
  - In-flight tag: r_if_valid and r_if_pc.
  - 2-entry FIFO of {pc, inst} with r_count in 0..2.
- pop = w_out_valid && w_out_ready.
- issue = !w_redirect && (r_count + r_if_valid - pop) < 2.
- On issue:
  - r_if_valid <= 1.
  - r_if_pc <= r_pc.
  - r_pc <= r_pc + 4, modulo 2^32.
- Otherwise r_if_valid <= 0 and r_pc holds.
- Memory behaviour:
  - The memory reads unconditionally every cycle.
  - Returned data with r_if_valid=0 is ignored.
- Capture: when r_if_valid=1, {r_if_pc, w_imem_inst} is pushed into the FIFO.
  - The issue rule guarantees the FIFO never overflows.
  - Push and pop in the same cycle are both honoured.
- Redirect (w_redirect=1):
  - A pop in the same cycle completes first.
  - Then the FIFO is flushed (r_count <= 0) and r_if_valid <= 0.
  - r_pc <= {w_redirect_pc[31:2], 2'b00}.
  - No issue occurs this cycle.
- Address aliasing: only pc[7:2] reaches memory, so PC 0x100 aliases word 0. The fetch unit does not check range.
- w_out_pc/w_out_inst show the FIFO head. Their value is don't-care when w_out_valid=0, but reset clears the storage to 0.
- Reset outputs:
  - r_pc = RESET_PC, so w_imem_addr = RESET_PC[7:2].
  - w_out_valid = 0; r_if_valid = 0; r_count = 0.
  - w_out_pc = 0; w_out_inst = 0.
  - Counters = 0.
- Reset has priority over redirect and handshake, including mid-stream: all buffered and in-flight words are dropped.

## Timing
- Issue at cycle T (address P[7:2] driven):
  - The word is in w_imem_inst during T+1.
  - It is written to the FIFO at the end of T+1.
  - w_out_valid=1 in T+2.
  - Latency is 2 cycles issue-to-valid.
- Throughput: 1 instruction/cycle sustained while w_out_ready=1.
  - Steady state: r_count=1, r_if_valid=1.
- Backpressure: when w_out_ready drops, at most one further word lands, giving r_count=2, and issue stops.
  - Issue resumes in the cycle where pop makes the sum < 2.
- Redirect at cycle R:
  - Target issued at R+1.
  - First target instruction valid at R+3.
- w_out_valid and the head entry must stay stable while w_out_ready=0 and no redirect occurs.

## Configuration
- FETCH_PERFCNT_EN defined:
  - w_fetch_count increments by 1 per pop.
  - w_squash_count increments by (r_count - pop) + r_if_valid on each redirect.
  - Both counters are 32-bit, wrap, and are cleared by w_rst.
- FETCH_PERFCNT_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Memory preload: mem[0]=0x00100093, mem[1]=0x00200113, mem[2]=0x002081B3. Unused words 0. RESET_PC=0.
- Reset release with w_out_ready=1:
  - w_out_valid first high 2 cycles after reset deasserts.
  - Three consecutive cycles show (pc,inst) = (0,0x00100093), (4,0x00200113), (8,0x002081B3).
- Hold w_out_ready=0 for 5 cycles after the first valid:
  - The head stays (0,0x00100093).
  - r_count reaches 2 and w_imem_addr stops advancing at 2.
  - On release, order is 0, 4, 8 with no gaps and no duplicates.
- Redirect to 0x8 while the head is pc 0 and w_out_ready=1:
  - pc 0 is delivered.
  - pc 4 never appears.
  - The next valid is (8,0x002081B3), 3 cycles after redirect.
  - w_squash_count (FETCH_PERFCNT_EN) grows by the discarded count.
- Redirect to 0xFD: bits [1:0] are cleared, so the PC becomes 0xFC, then 0x100 aliases word 0 (inst 0x00100093 at pc 0x100).
- Assert w_rst mid-stream with the FIFO full:
  - Next cycle w_out_valid=0 and w_imem_addr=0.
  - Counters are 0.
  - The sequence restarts at pc 0.
